// File: rtl/dispatch_queue_pkg.sv
// Shared opcode encoding and field widths for the dispatch queue and its
// operand resolver.
package dispatch_queue_pkg;

    localparam int REG_POS_W = 5;

    typedef enum logic [5:0] {
        OPENUM_NOP  = 6'd0,
        OPENUM_ADD  = 6'd1,
        OPENUM_ADDI = 6'd2,
        OPENUM_BEQ  = 6'd3,
        OPENUM_LB   = 6'd10,
        OPENUM_LH   = 6'd11,
        OPENUM_LW   = 6'd12,
        OPENUM_LBU  = 6'd13,
        OPENUM_LHU  = 6'd14,
        OPENUM_SB   = 6'd15,
        OPENUM_SH   = 6'd16,
        OPENUM_SW   = 6'd17
    } openum_e;

endpackage

// File: rtl/operand_resolve.sv
// Resolves one source operand to a (tag, value) pair from the rename bypass,
// regfile, CDB channels and ROB ready data, in that priority order.
module operand_resolve
    import dispatch_queue_pkg::*;
#(
    parameter int NUM_CDB  = 2,
    parameter int ROB_ID_W = 4,
    parameter int DATA_W   = 32
) (
    input  logic [REG_POS_W-1:0]        rs,
    input  logic                        last_valid,
    input  logic [REG_POS_W-1:0]        last_rd,
    input  logic [ROB_ID_W-1:0]         last_rob_id,
    input  logic [ROB_ID_W-1:0]         q_from_reg,
    input  logic [DATA_W-1:0]           v_from_reg,
    input  logic                        q_ready_from_rob,
    input  logic [DATA_W-1:0]           ready_data_from_rob,
    input  logic [NUM_CDB-1:0]          cdb_valid,
    input  logic [NUM_CDB*ROB_ID_W-1:0] cdb_rob_id,
    input  logic [NUM_CDB*DATA_W-1:0]   cdb_result,
    output logic [ROB_ID_W-1:0]         q,
    output logic [DATA_W-1:0]           v
);

    logic              cdb_hit;
    logic [DATA_W-1:0] cdb_data;

    // Scan from the top so the lowest-index matching channel is the one kept.
    always_comb begin
        cdb_hit  = 1'b0;
        cdb_data = '0;
        for (int i = NUM_CDB - 1; i >= 0; i--) begin
            if (cdb_valid[i] && cdb_rob_id[i*ROB_ID_W +: ROB_ID_W] == q_from_reg) begin
                cdb_hit  = 1'b1;
                cdb_data = cdb_result[i*DATA_W +: DATA_W];
            end
        end
    end

    // NOTE: every output gets a default before the priority chain, so no latch is inferred.
    always_comb begin
        q = '0;
        v = '0;
        if (rs != '0) begin
            if (last_valid && last_rd == rs)  q = last_rob_id;
            else if (q_from_reg == '0)        v = v_from_reg;
            else if (cdb_hit)                 v = cdb_data;
            else if (q_ready_from_rob)        v = ready_data_from_rob;
            else                              q = q_from_reg;
        end
    end

endmodule

// File: rtl/dispatch_queue.sv
// DEPTH-entry dispatch FIFO: buffers decoded instructions and issues the head
// to ROB/RS/LSB/regfile with registered one-cycle enable pulses.
module dispatch_queue
    import dispatch_queue_pkg::*;
#(
    parameter int DEPTH    = 4,
    parameter int NUM_CDB  = 2,
    parameter int ROB_ID_W = 4,
    parameter int DATA_W   = 32,
    parameter int OPENUM_W = 6
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        rdy,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [OPENUM_W-1:0]         in_openum,
    input  logic [REG_POS_W-1:0]        in_rd,
    input  logic [REG_POS_W-1:0]        in_rs1,
    input  logic [REG_POS_W-1:0]        in_rs2,
    input  logic [DATA_W-1:0]           in_imm,
    input  logic [DATA_W-1:0]           in_pc,
    input  logic [DATA_W-1:0]           in_rollback_pc,
    input  logic                        in_is_jump,
    input  logic                        in_pred_jump,
    output logic [REG_POS_W-1:0]        rs1_to_reg,
    output logic [REG_POS_W-1:0]        rs2_to_reg,
    input  logic [DATA_W-1:0]           V1_from_reg,
    input  logic [DATA_W-1:0]           V2_from_reg,
    input  logic [ROB_ID_W-1:0]         Q1_from_reg,
    input  logic [ROB_ID_W-1:0]         Q2_from_reg,
    output logic [ROB_ID_W-1:0]         Q1_to_rob,
    output logic [ROB_ID_W-1:0]         Q2_to_rob,
    input  logic                        Q1_ready_from_rob,
    input  logic                        Q2_ready_from_rob,
    input  logic [DATA_W-1:0]           ready_data1_from_rob,
    input  logic [DATA_W-1:0]           ready_data2_from_rob,
    input  logic [ROB_ID_W-1:0]         rob_id_from_rob,
    input  logic                        rob_full,
    input  logic                        rs_full,
    input  logic                        lsb_full,
    input  logic [NUM_CDB-1:0]          cdb_valid,
    input  logic [NUM_CDB*ROB_ID_W-1:0] cdb_rob_id,
    input  logic [NUM_CDB*DATA_W-1:0]   cdb_result,
    input  logic                        rollback,
    output logic                        ena_to_rob,
    output logic                        ena_to_rs,
    output logic                        ena_to_lsb,
    output logic                        ena_to_reg,
    output logic [OPENUM_W-1:0]         out_openum,
    output logic [DATA_W-1:0]           out_V1,
    output logic [DATA_W-1:0]           out_V2,
    output logic [DATA_W-1:0]           out_imm,
    output logic [DATA_W-1:0]           out_pc,
    output logic [DATA_W-1:0]           out_rollback_pc,
    output logic [ROB_ID_W-1:0]         out_Q1,
    output logic [ROB_ID_W-1:0]         out_Q2,
    output logic [ROB_ID_W-1:0]         out_rob_id,
    output logic [REG_POS_W-1:0]        out_rd,
    output logic                        out_is_jump,
    output logic                        out_pred_jump
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W:0]   wr_ptr, rd_ptr;
    logic [PTR_W-1:0] wr_idx, rd_idx;
    logic             empty, full, head_is_ls, do_enq, do_store, issue;

    logic [OPENUM_W-1:0]  mem_openum    [DEPTH];
    logic [REG_POS_W-1:0] mem_rd        [DEPTH];
    logic [REG_POS_W-1:0] mem_rs1       [DEPTH];
    logic [REG_POS_W-1:0] mem_rs2       [DEPTH];
    logic [DATA_W-1:0]    mem_imm       [DEPTH];
    logic [DATA_W-1:0]    mem_pc        [DEPTH];
    logic [DATA_W-1:0]    mem_rb_pc     [DEPTH];
    logic                 mem_is_jump   [DEPTH];
    logic                 mem_pred_jump [DEPTH];

    logic                 last_valid;
    logic [REG_POS_W-1:0] last_rd;
    logic [ROB_ID_W-1:0]  last_rob_id;
    logic [ROB_ID_W-1:0]  q1, q2;
    logic [DATA_W-1:0]    v1, v2;

    assign wr_idx   = wr_ptr[PTR_W-1:0];
    assign rd_idx   = rd_ptr[PTR_W-1:0];
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) && (wr_idx == rd_idx);
    assign in_ready = !full;

    // NOPs complete the handshake but never occupy a slot.
    assign do_enq     = in_valid && in_ready && rdy && !rollback;
    assign do_store   = do_enq && (in_openum != OPENUM_W'(OPENUM_NOP));
    assign head_is_ls = (mem_openum[rd_idx] >= OPENUM_W'(OPENUM_LB)) &&
                        (mem_openum[rd_idx] <= OPENUM_W'(OPENUM_SW));
    assign issue      = !empty && rdy && !rollback && !rob_full &&
                        (head_is_ls ? !lsb_full : !rs_full);

    assign rs1_to_reg = mem_rs1[rd_idx];
    assign rs2_to_reg = mem_rs2[rd_idx];
    assign Q1_to_rob  = Q1_from_reg;
    assign Q2_to_rob  = Q2_from_reg;

    operand_resolve #(.NUM_CDB(NUM_CDB), .ROB_ID_W(ROB_ID_W), .DATA_W(DATA_W)) u_resolve_rs1 (
        .rs(mem_rs1[rd_idx]), .last_valid(last_valid), .last_rd(last_rd), .last_rob_id(last_rob_id),
        .q_from_reg(Q1_from_reg), .v_from_reg(V1_from_reg),
        .q_ready_from_rob(Q1_ready_from_rob), .ready_data_from_rob(ready_data1_from_rob),
        .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id), .cdb_result(cdb_result),
        .q(q1), .v(v1)
    );

    operand_resolve #(.NUM_CDB(NUM_CDB), .ROB_ID_W(ROB_ID_W), .DATA_W(DATA_W)) u_resolve_rs2 (
        .rs(mem_rs2[rd_idx]), .last_valid(last_valid), .last_rd(last_rd), .last_rob_id(last_rob_id),
        .q_from_reg(Q2_from_reg), .v_from_reg(V2_from_reg),
        .q_ready_from_rob(Q2_ready_from_rob), .ready_data_from_rob(ready_data2_from_rob),
        .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id), .cdb_result(cdb_result),
        .q(q2), .v(v2)
    );

    // NOTE: storage is not reset; the pointers alone define which slots hold valid data.
    always_ff @(posedge clk) begin
        if (do_store) begin
            mem_openum[wr_idx]    <= in_openum;
            mem_rd[wr_idx]        <= in_rd;
            mem_rs1[wr_idx]       <= in_rs1;
            mem_rs2[wr_idx]       <= in_rs2;
            mem_imm[wr_idx]       <= in_imm;
            mem_pc[wr_idx]        <= in_pc;
            mem_rb_pc[wr_idx]     <= in_rollback_pc;
            mem_is_jump[wr_idx]   <= in_is_jump;
            mem_pred_jump[wr_idx] <= in_pred_jump;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            last_valid      <= 1'b0;
            last_rd         <= '0;
            last_rob_id     <= '0;
            ena_to_rob      <= 1'b0;
            ena_to_rs       <= 1'b0;
            ena_to_lsb      <= 1'b0;
            ena_to_reg      <= 1'b0;
            out_openum      <= '0;
            out_V1          <= '0;
            out_V2          <= '0;
            out_imm         <= '0;
            out_pc          <= '0;
            out_rollback_pc <= '0;
            out_Q1          <= '0;
            out_Q2          <= '0;
            out_rob_id      <= '0;
            out_rd          <= '0;
            out_is_jump     <= 1'b0;
            out_pred_jump   <= 1'b0;
        end else if (!rdy) begin
            ena_to_rob <= 1'b0;
            ena_to_rs  <= 1'b0;
            ena_to_lsb <= 1'b0;
            ena_to_reg <= 1'b0;
        end else begin
            ena_to_rob <= issue;
            ena_to_rs  <= issue && !head_is_ls;
            ena_to_lsb <= issue && head_is_ls;
            ena_to_reg <= issue && (mem_rd[rd_idx] != '0);
            if (rollback) begin
                wr_ptr     <= '0;
                rd_ptr     <= '0;
                last_valid <= 1'b0;
            end else begin
                last_valid <= issue;
                if (do_store) wr_ptr <= wr_ptr + 1'b1;
                if (issue) begin
                    rd_ptr          <= rd_ptr + 1'b1;
                    last_rd         <= mem_rd[rd_idx];
                    last_rob_id     <= rob_id_from_rob;
                    out_openum      <= mem_openum[rd_idx];
                    out_V1          <= v1;
                    out_V2          <= v2;
                    out_Q1          <= q1;
                    out_Q2          <= q2;
                    out_imm         <= mem_imm[rd_idx];
                    out_pc          <= mem_pc[rd_idx];
                    out_rollback_pc <= mem_rb_pc[rd_idx];
                    out_rob_id      <= rob_id_from_rob;
                    out_rd          <= mem_rd[rd_idx];
                    out_is_jump     <= mem_is_jump[rd_idx];
                    out_pred_jump   <= mem_pred_jump[rd_idx];
                end
            end
        end
    end

endmodule

// File: tb/tb_dispatch_queue.sv
// Directed scenarios plus randomized traffic against a queue-based reference
// model of the dispatch queue.
module tb_dispatch_queue;
    import dispatch_queue_pkg::*;

    localparam int DEPTH = 4, NUM_CDB = 2, ROB_ID_W = 4, DATA_W = 32, OPENUM_W = 6;
    localparam int OUT_W = OPENUM_W + 5*DATA_W + 3*ROB_ID_W + 5 + 2;

    logic clk = 1'b0;
    logic rst, rdy, in_valid, in_ready, in_is_jump, in_pred_jump;
    logic [OPENUM_W-1:0] in_openum, out_openum;
    logic [4:0] in_rd, in_rs1, in_rs2, rs1_to_reg, rs2_to_reg, out_rd;
    logic [DATA_W-1:0] in_imm, in_pc, in_rollback_pc, V1_from_reg, V2_from_reg;
    logic [ROB_ID_W-1:0] Q1_from_reg, Q2_from_reg, Q1_to_rob, Q2_to_rob, rob_id_from_rob;
    logic Q1_ready_from_rob, Q2_ready_from_rob, rob_full, rs_full, lsb_full, rollback;
    logic [DATA_W-1:0] ready_data1_from_rob, ready_data2_from_rob;
    logic [NUM_CDB-1:0] cdb_valid;
    logic [NUM_CDB*ROB_ID_W-1:0] cdb_rob_id;
    logic [NUM_CDB*DATA_W-1:0] cdb_result;
    logic ena_to_rob, ena_to_rs, ena_to_lsb, ena_to_reg, out_is_jump, out_pred_jump;
    logic [DATA_W-1:0] out_V1, out_V2, out_imm, out_pc, out_rollback_pc;
    logic [ROB_ID_W-1:0] out_Q1, out_Q2, out_rob_id;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [5:0] openum;
        logic [4:0] rd, rs1, rs2;
        logic [31:0] imm, pc, rpc;
        logic jmp, pj;
    } entry_t;

    entry_t mq[$];
    logic m_last_valid;
    logic [4:0] m_last_rd;
    logic [3:0] m_last_tag;
    logic [OUT_W-1:0] exp_out;

    dispatch_queue #(.DEPTH(DEPTH), .NUM_CDB(NUM_CDB), .ROB_ID_W(ROB_ID_W),
                     .DATA_W(DATA_W), .OPENUM_W(OPENUM_W)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .in_valid(in_valid), .in_ready(in_ready),
        .in_openum(in_openum), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_imm(in_imm), .in_pc(in_pc), .in_rollback_pc(in_rollback_pc),
        .in_is_jump(in_is_jump), .in_pred_jump(in_pred_jump),
        .rs1_to_reg(rs1_to_reg), .rs2_to_reg(rs2_to_reg),
        .V1_from_reg(V1_from_reg), .V2_from_reg(V2_from_reg),
        .Q1_from_reg(Q1_from_reg), .Q2_from_reg(Q2_from_reg),
        .Q1_to_rob(Q1_to_rob), .Q2_to_rob(Q2_to_rob),
        .Q1_ready_from_rob(Q1_ready_from_rob), .Q2_ready_from_rob(Q2_ready_from_rob),
        .ready_data1_from_rob(ready_data1_from_rob), .ready_data2_from_rob(ready_data2_from_rob),
        .rob_id_from_rob(rob_id_from_rob), .rob_full(rob_full), .rs_full(rs_full),
        .lsb_full(lsb_full), .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id),
        .cdb_result(cdb_result), .rollback(rollback),
        .ena_to_rob(ena_to_rob), .ena_to_rs(ena_to_rs), .ena_to_lsb(ena_to_lsb),
        .ena_to_reg(ena_to_reg), .out_openum(out_openum), .out_V1(out_V1), .out_V2(out_V2),
        .out_imm(out_imm), .out_pc(out_pc), .out_rollback_pc(out_rollback_pc),
        .out_Q1(out_Q1), .out_Q2(out_Q2), .out_rob_id(out_rob_id), .out_rd(out_rd),
        .out_is_jump(out_is_jump), .out_pred_jump(out_pred_jump)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        rdy = 1'b1; in_valid = 1'b0; in_openum = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
        in_imm = '0; in_pc = '0; in_rollback_pc = '0; in_is_jump = 1'b0; in_pred_jump = 1'b0;
        V1_from_reg = 32'h11; V2_from_reg = 32'h22; Q1_from_reg = '0; Q2_from_reg = '0;
        Q1_ready_from_rob = 1'b0; Q2_ready_from_rob = 1'b0;
        ready_data1_from_rob = '0; ready_data2_from_rob = '0; rob_id_from_rob = '0;
        rob_full = 1'b0; rs_full = 1'b0; lsb_full = 1'b0; rollback = 1'b0;
        cdb_valid = '0; cdb_rob_id = '0; cdb_result = '0;
    endtask

    task automatic drive_instr(input logic [5:0] op, input logic [4:0] rd, rs1, rs2,
                               input logic [31:0] imm);
        in_valid = 1'b1; in_openum = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
        in_imm = imm; in_pc = 32'h1000 + imm; in_rollback_pc = 32'h2000 + imm;
        in_is_jump = 1'b0; in_pred_jump = 1'b0;
    endtask

    function automatic logic is_ls(input logic [5:0] op);
        return (op >= OPENUM_LB) && (op <= OPENUM_SW);
    endfunction

    // Spec-level operand rule: first matching source wins.
    task automatic model_resolve(input logic [4:0] rs, input logic [3:0] qreg,
                                 input logic [31:0] vreg, input logic rob_rdy,
                                 input logic [31:0] rob_data,
                                 output logic [3:0] q, output logic [31:0] v);
        bit found;
        q = 4'd0; v = 32'd0; found = 0;
        if (rs == 0) return;
        if (m_last_valid && m_last_rd == rs) begin q = m_last_tag; return; end
        if (qreg == 0) begin v = vreg; return; end
        for (int i = 0; i < NUM_CDB; i++) begin
            if (!found && cdb_valid[i] && cdb_rob_id[i*4 +: 4] == qreg) begin
                v = cdb_result[i*32 +: 32]; found = 1;
            end
        end
        if (found) return;
        if (rob_rdy) v = rob_data;
        else q = qreg;
    endtask

    task automatic apply_reset();
        drive_idle();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        mq.delete(); m_last_valid = 1'b0; m_last_rd = '0; m_last_tag = '0; exp_out = '0;
    endtask

    task automatic test_reset();
        n_cmp++;
        if ({ena_to_rob, ena_to_rs, ena_to_lsb, ena_to_reg} !== 4'b0) begin
            n_bad++; $display("FAIL reset_ena: got %b want 0000", {ena_to_rob, ena_to_rs, ena_to_lsb, ena_to_reg});
        end
        n_cmp++;
        if ({out_openum, out_V1, out_V2, out_imm, out_pc, out_rollback_pc, out_Q1, out_Q2,
             out_rob_id, out_rd, out_is_jump, out_pred_jump} !== '0) begin
            n_bad++; $display("FAIL reset_out: out_* not all zero (rob_id=%0d imm=%h)", out_rob_id, out_imm);
        end
        n_cmp++;
        if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_basic_issue();
        drive_instr(OPENUM_ADDI, 5'd5, 5'd0, 5'd0, 32'd7);
        rob_id_from_rob = 4'd3;
        tick();
        in_valid = 1'b0;
        n_cmp++;
        if (ena_to_rob !== 1'b0) begin n_bad++; $display("FAIL basic_no_early_ena: got %b want 0", ena_to_rob); end
        tick();
        n_cmp++;
        if ({ena_to_rob, ena_to_rs, ena_to_lsb, ena_to_reg} !== 4'b1101) begin
            n_bad++; $display("FAIL basic_ena: got %b want 1101", {ena_to_rob, ena_to_rs, ena_to_lsb, ena_to_reg});
        end
        n_cmp++;
        if ({out_V1, out_Q1, out_rob_id, out_imm, out_rd} !== {32'd0, 4'd0, 4'd3, 32'd7, 5'd5}) begin
            n_bad++; $display("FAIL basic_fields: got V1=%h Q1=%0d rob_id=%0d imm=%h rd=%0d want 0 0 3 7 5",
                              out_V1, out_Q1, out_rob_id, out_imm, out_rd);
        end
        tick();
        n_cmp++;
        if ({ena_to_rob, out_rob_id} !== {1'b0, 4'd3}) begin
            n_bad++; $display("FAIL basic_pulse: got ena=%b rob_id=%0d want 0 3", ena_to_rob, out_rob_id);
        end
    endtask

    task automatic test_back_to_back();
        drive_instr(OPENUM_ADD, 5'd5, 5'd1, 5'd2, 32'd0);
        rob_id_from_rob = 4'd3;
        tick();
        drive_instr(OPENUM_ADD, 5'd6, 5'd5, 5'd5, 32'd1);
        tick();
        in_valid = 1'b0;
        rob_id_from_rob = 4'd4;
        n_cmp++;
        if ({ena_to_rob, out_rob_id, out_V1, out_V2} !== {1'b1, 4'd3, 32'h11, 32'h22}) begin
            n_bad++; $display("FAIL b2b_first: got ena=%b rob_id=%0d V1=%h V2=%h want 1 3 11 22",
                              ena_to_rob, out_rob_id, out_V1, out_V2);
        end
        tick();
        n_cmp++;
        if ({ena_to_rob, out_Q1, out_Q2, out_V1, out_rob_id, out_rd} !==
            {1'b1, 4'd3, 4'd3, 32'd0, 4'd4, 5'd6}) begin
            n_bad++; $display("FAIL b2b_bypass: got ena=%b Q1=%0d Q2=%0d V1=%h rob_id=%0d rd=%0d want 1 3 3 0 4 6",
                              ena_to_rob, out_Q1, out_Q2, out_V1, out_rob_id, out_rd);
        end
        tick();
    endtask

    task automatic test_cdb_forward();
        drive_instr(OPENUM_ADD, 5'd7, 5'd3, 5'd4, 32'd2);
        tick();
        in_valid = 1'b0;
        Q1_from_reg = 4'd4;
        Q1_ready_from_rob = 1'b1; ready_data1_from_rob = 32'h5555;
        cdb_valid = 2'b11;
        cdb_rob_id = {4'd4, 4'd9};
        cdb_result = {32'hDEAD, 32'hBEEF};
        tick();
        n_cmp++;
        if ({ena_to_rob, out_Q1, out_V1, out_Q2, out_V2} !== {1'b1, 4'd0, 32'hDEAD, 4'd0, 32'h22}) begin
            n_bad++; $display("FAIL cdb_forward: got ena=%b Q1=%0d V1=%h Q2=%0d V2=%h want 1 0 dead 0 22",
                              ena_to_rob, out_Q1, out_V1, out_Q2, out_V2);
        end
        drive_idle();
        tick();
    endtask

    task automatic test_full_lsb();
        lsb_full = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            drive_instr(OPENUM_LW, 5'(i + 1), 5'd1, 5'd0, 32'(i));
            tick();
        end
        in_valid = 1'b0;
        n_cmp++;
        if ({in_ready, ena_to_lsb, ena_to_rob} !== 3'b000) begin
            n_bad++; $display("FAIL full_hold: got in_ready=%b ena_lsb=%b ena_rob=%b want 000",
                              in_ready, ena_to_lsb, ena_to_rob);
        end
        lsb_full = 1'b0;
        tick();
        n_cmp++;
        if ({ena_to_lsb, ena_to_rs, in_ready, out_rd} !== {1'b1, 1'b0, 1'b1, 5'd1}) begin
            n_bad++; $display("FAIL full_release: got ena_lsb=%b ena_rs=%b in_ready=%b rd=%0d want 1 0 1 1",
                              ena_to_lsb, ena_to_rs, in_ready, out_rd);
        end
        for (int i = 0; i < DEPTH; i++) tick();
    endtask

    task automatic test_rollback();
        rs_full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_instr(OPENUM_ADD, 5'd2, 5'd1, 5'd1, 32'(i));
            tick();
        end
        drive_instr(OPENUM_ADDI, 5'd3, 5'd0, 5'd0, 32'h99);
        rollback = 1'b1;
        tick();
        rollback = 1'b0; rs_full = 1'b0; in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if ({ena_to_rob, in_ready} !== 2'b01) begin
                n_bad++; $display("FAIL rollback_empty_%0d: got ena=%b in_ready=%b want 0 1", i, ena_to_rob, in_ready);
            end
            tick();
        end
    endtask

    task automatic test_async_reset();
        drive_instr(OPENUM_ADDI, 5'd9, 5'd0, 5'd0, 32'h77);
        rob_id_from_rob = 4'd5;
        tick();
        in_valid = 1'b0;
        tick();
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({ena_to_rob, ena_to_reg, out_rob_id, out_imm, out_rd, in_ready} !== {2'b00, 4'd0, 32'd0, 5'd0, 1'b1}) begin
            n_bad++; $display("FAIL async_reset: got ena=%b%b rob_id=%0d imm=%h rd=%0d in_ready=%b want 00 0 0 0 1",
                              ena_to_rob, ena_to_reg, out_rob_id, out_imm, out_rd, in_ready);
        end
        #1 rst = 1'b0;
        tick();
        n_cmp++;
        if (ena_to_rob !== 1'b0) begin n_bad++; $display("FAIL async_reset_empty: got ena=%b want 0", ena_to_rob); end
    endtask

    function automatic logic [5:0] pick_op(input int k);
        case (k)
            0: return OPENUM_NOP;
            1: return OPENUM_ADD;
            2: return OPENUM_ADDI;
            3: return OPENUM_BEQ;
            4: return OPENUM_LB;
            5: return OPENUM_LW;
            default: return OPENUM_SW;
        endcase
    endfunction

    task automatic test_random();
        entry_t h, e;
        logic [3:0] exp_ena, q1, q2;
        logic [31:0] v1, v2;
        bit accept, iss;
        apply_reset();
        for (int cyc = 0; cyc < 1500; cyc++) begin
            rdy = ($urandom_range(0, 9) != 0);
            in_valid = ($urandom_range(0, 9) < 6);
            in_openum = pick_op($urandom_range(0, 6));
            in_rd = 5'($urandom_range(0, 7)); in_rs1 = 5'($urandom_range(0, 7)); in_rs2 = 5'($urandom_range(0, 7));
            in_imm = $urandom; in_pc = $urandom; in_rollback_pc = $urandom;
            in_is_jump = 1'($urandom); in_pred_jump = 1'($urandom);
            V1_from_reg = $urandom; V2_from_reg = $urandom;
            Q1_from_reg = 4'($urandom_range(0, 7)); Q2_from_reg = 4'($urandom_range(0, 7));
            Q1_ready_from_rob = ($urandom_range(0, 2) == 0); Q2_ready_from_rob = ($urandom_range(0, 2) == 0);
            ready_data1_from_rob = $urandom; ready_data2_from_rob = $urandom;
            rob_id_from_rob = 4'($urandom);
            rob_full = ($urandom_range(0, 4) == 0); rs_full = ($urandom_range(0, 4) == 0);
            lsb_full = ($urandom_range(0, 4) == 0); rollback = ($urandom_range(0, 32) == 0);
            cdb_valid = 2'($urandom);
            cdb_rob_id = {4'($urandom_range(0, 7)), 4'($urandom_range(0, 7))};
            cdb_result = {$urandom, $urandom};
            #1;
            n_cmp++;
            if (in_ready !== (mq.size() < DEPTH)) begin
                n_bad++; $display("FAIL rand_in_ready cyc %0d: got %b want %b", cyc, in_ready, mq.size() < DEPTH);
            end
            if (mq.size() > 0) begin
                n_cmp++;
                if ({rs1_to_reg, rs2_to_reg} !== {mq[0].rs1, mq[0].rs2}) begin
                    n_bad++; $display("FAIL rand_reg_query cyc %0d: got %0d/%0d want %0d/%0d",
                                      cyc, rs1_to_reg, rs2_to_reg, mq[0].rs1, mq[0].rs2);
                end
            end
            exp_ena = 4'b0;
            if (rdy) begin
                if (rollback) begin
                    mq.delete();
                    m_last_valid = 1'b0;
                end else begin
                    accept = in_valid && (mq.size() < DEPTH);
                    iss = (mq.size() > 0) && !rob_full && (is_ls(mq[0].openum) ? !lsb_full : !rs_full);
                    if (iss) begin
                        h = mq.pop_front();
                        model_resolve(h.rs1, Q1_from_reg, V1_from_reg, Q1_ready_from_rob, ready_data1_from_rob, q1, v1);
                        model_resolve(h.rs2, Q2_from_reg, V2_from_reg, Q2_ready_from_rob, ready_data2_from_rob, q2, v2);
                        exp_out = {h.openum, v1, v2, h.imm, h.pc, h.rpc, q1, q2, rob_id_from_rob, h.rd, h.jmp, h.pj};
                        exp_ena = {1'b1, !is_ls(h.openum), is_ls(h.openum), h.rd != 0};
                        m_last_valid = 1'b1; m_last_rd = h.rd; m_last_tag = rob_id_from_rob;
                    end else begin
                        m_last_valid = 1'b0;
                    end
                    if (accept && in_openum != OPENUM_NOP) begin
                        e = '{openum: in_openum, rd: in_rd, rs1: in_rs1, rs2: in_rs2, imm: in_imm,
                              pc: in_pc, rpc: in_rollback_pc, jmp: in_is_jump, pj: in_pred_jump};
                        mq.push_back(e);
                    end
                end
            end
            tick();
            n_cmp++;
            if ({ena_to_rob, ena_to_rs, ena_to_lsb, ena_to_reg} !== exp_ena) begin
                n_bad++; $display("FAIL rand_ena cyc %0d: got %b want %b", cyc,
                                  {ena_to_rob, ena_to_rs, ena_to_lsb, ena_to_reg}, exp_ena);
            end
            n_cmp++;
            if ({out_openum, out_V1, out_V2, out_imm, out_pc, out_rollback_pc, out_Q1, out_Q2,
                 out_rob_id, out_rd, out_is_jump, out_pred_jump} !== exp_out) begin
                n_bad++; $display("FAIL rand_out cyc %0d: got %h want %h", cyc,
                                  {out_openum, out_V1, out_V2, out_imm, out_pc, out_rollback_pc, out_Q1, out_Q2,
                                   out_rob_id, out_rd, out_is_jump, out_pred_jump}, exp_out);
            end
        end
    endtask

    initial begin
        apply_reset();
        test_reset();
        test_basic_issue();
        test_back_to_back();
        test_cdb_forward();
        test_full_lsb();
        test_rollback();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dispatch_queue.md
Name: dispatch_queue

Overview:
- Parametrised successor to the single-slot dispatch stage in the Tomasulo core.
- Buffers decoded instructions from the decoder/fetch side in a DEPTH-entry FIFO and issues the head to ROB + RS/LSB + regfile rename.
- Honours back-pressure from ROB/RS/LSB and resolves operands through regfile, ROB ready data, NUM_CDB CDB channels, and a back-to-back rename bypass.
- Flushes completely on rollback.

Parameters:
- DEPTH, 4, FIFO entries; must be a power of 2, at least 2.
- NUM_CDB, 2, number of CDB broadcast channels.
- ROB_ID_W, 4, ROB tag width; tag 0 (ZERO_ROB) means "no dependency".
- DATA_W, 32, data, immediate and address width.
- OPENUM_W, 6, opcode-enum width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- rdy  in  1  global ready; low freezes the block.
- in_valid  in  1  decoded instruction valid.
- in_ready  out  1  FIFO can accept this cycle.
- in_openum / in_rd / in_rs1 / in_rs2  in  OPENUM_W/5/5/5  decoded fields.
- in_imm / in_pc / in_rollback_pc  in  DATA_W  immediate, pc, rollback pc.
- in_is_jump / in_pred_jump  in  1  branch flag, predicted taken.
- rs1_to_reg / rs2_to_reg  out  5  combinational regfile query of the head entry.
- V1_from_reg / V2_from_reg  in  DATA_W; Q1_from_reg / Q2_from_reg  in  ROB_ID_W.
- Q1_to_rob / Q2_to_rob  out  ROB_ID_W  equal to Q*_from_reg.
- Q1_ready_from_rob / Q2_ready_from_rob  in  1; ready_data1/2_from_rob  in  DATA_W.
- rob_id_from_rob  in  ROB_ID_W  tag the next allocation receives.
- rob_full / rs_full / lsb_full  in  1  consumer back-pressure.
- cdb_valid  in  NUM_CDB; cdb_rob_id  in  NUM_CDB*ROB_ID_W; cdb_result  in  NUM_CDB*DATA_W.
- rollback  in  1  mispredict flush.
- ena_to_rob / ena_to_rs / ena_to_lsb / ena_to_reg  out  1  registered one-cycle issue pulses.
- out_openum  out  OPENUM_W.
- out_V1 / out_V2 / out_imm / out_pc / out_rollback_pc  out  DATA_W.
- out_Q1 / out_Q2 / out_rob_id  out  ROB_ID_W.
- out_rd  out  5; out_is_jump / out_pred_jump  out  1.
- All out_* fields are shared by ROB, RS, LSB and regfile.

Behaviour:
- Reset (async, rst=1): FIFO empty (pointers and count 0), all ena_* 0, all out_* 0, last-issue record cleared.
- in_ready = (count < DEPTH); it never depends on in_valid.
- Enqueue when in_valid && in_ready && rdy && !rollback. OPENUM_NOP is accepted but not stored.
- Pointers are log2(DEPTH)+1 bits and wrap naturally. Full = MSB differs and low bits equal.
- is_ls = OPENUM_LB <= openum <= OPENUM_SW.
- issue = count>0 && rdy && !rollback && !rob_full && (is_ls ? !lsb_full : !rs_full).
- Consumers assert *_full when fewer than 2 slots are free, because issue is registered.
- On issue, at the clock edge:
  - head pops;
  - ena_to_rob = 1;
  - ena_to_lsb = is_ls, ena_to_rs = !is_ls;
  - ena_to_reg = (rd != 0);
  - out_rob_id = rob_id_from_rob;
  - fields are copied;
  - last-issue record = {valid, rd, rob_id}.
- With no issue, all ena_* are 0 next cycle. out_* data holds its value.
- Enqueue and issue in the same cycle: count unchanged. An entry enqueued at edge k can issue at edge k+1 at the earliest, so ena goes high 2 cycles after acceptance. There is no FIFO bypass.
- Operand resolution per source, first match wins:
  1. rs == 0: Q=0, V=0.
  2. last-issue valid && its rd == rs && rd != 0: Q = last rob_id, V = 0 (rename bypass).
  3. Q_from_reg == 0: V = V_from_reg.
  4. Lowest-index CDB channel valid with matching tag: Q=0, V = that result.
  5. Q*_ready_from_rob: Q=0, V = ROB data.
  6. Otherwise: Q = Q_from_reg, V = 0.
- Last-issue valid is cleared on any cycle without an issue.
- rollback = 1: FIFO emptied at that edge, ena_* 0 next cycle, last-issue cleared. rollback wins over enqueue and issue.
- rdy = 0: FIFO and last-issue are frozen; ena_* are forced to 0.

Decomposition:
- defines.v holds OPENUM_* values including LB/SW/NOP, ZERO_ROB, REG_POS_TYPE, DATA_TYPE, ADDR_TYPE and ROB_ID_TYPE widths.
- Sub-module operand_resolve (combinational, parametrised by NUM_CDB) is instantiated twice, once for rs1 and once for rs2.

Test Plan:
- Enqueue ADDI rd=5 rs1=0 imm=7, all consumers free, rob_id=3 -> 2 cycles later ena_to_rob=ena_to_rs=ena_to_reg=1, out_V1=0, out_Q1=0, out_rob_id=3, for one cycle.
- Back-to-back: ADD x5 issued with tag 3, then ADD x6,x5,x5 next cycle, regfile still shows Q=0 -> out_Q1=out_Q2=3.
- Head needs tag 4; cdb_valid[1]=1, cdb_rob_id[1]=4, cdb_result[1]=0xDEAD in the issue cycle -> out_Q1=0, out_V1=0xDEAD.
- Fill DEPTH=4 with lsb_full=1 and LW at head -> in_ready=0 after 4 accepts, no ena. Drop lsb_full -> ena_to_lsb=1 and in_ready=1 the next cycle.
- Rollback with 3 entries and in_valid=1 -> count=0, no ena next cycle, incoming instruction discarded.
- rst asserted mid-issue (asynchronous, between edges) -> all ena_* and out_* immediately 0, FIFO empty.
